// File: rtl/charram_dram_ctrl.sv
// Character-RAM controller for a 4416-style DRAM: registered RAS/CAS sequencing.
// Define CHARRAM_REFRESH_EN to add the periodic RAS-only refresh engine.
module charram_dram_ctrl #(
  parameter int unsigned REFRESH_INTERVAL = 128,
  parameter int unsigned PRECHARGE_CYCLES = 2
) (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_REQ,
  input  logic        i_WE,
  input  logic [13:0] i_ADDR,
  input  logic [3:0]  i_DIN,
  output logic [3:0]  o_DOUT,
  output logic        o_ACK,
  output logic        o_BUSY,
  output logic [7:0]  o_DRAM_ADDR,
  output logic        o_RAS_n,
  output logic        o_CAS_n,
  output logic        o_WR_n,
  output logic        o_RD_n,
  output logic [3:0]  o_DRAM_DOUT,
  input  logic [3:0]  i_DRAM_DIN
);

  if (REFRESH_INTERVAL < 16 || REFRESH_INTERVAL > 1023) begin : g_bad_refresh_interval
    $error("REFRESH_INTERVAL out of range 16..1023");
  end
  if (PRECHARGE_CYCLES < 1 || PRECHARGE_CYCLES > 7) begin : g_bad_precharge
    $error("PRECHARGE_CYCLES out of range 1..7");
  end

`ifdef CHARRAM_REFRESH_EN
  typedef enum logic [2:0] {IDLE, ROW, COL, ACC, RDLAT, PRE, REF} state_t;
`else
  typedef enum logic [2:0] {IDLE, ROW, COL, ACC, RDLAT, PRE} state_t;
`endif

  localparam logic [2:0] PRE_LAST = 3'(PRECHARGE_CYCLES - 1);

  state_t      state, state_n;
  logic [13:0] addr_q, addr_n;
  logic        we_q, we_n;
  logic [3:0]  din_q, din_n;
  logic [2:0]  pre_cnt_q, pre_cnt_n;

  logic [3:0]  dout_n, dram_dout_n;
  logic [7:0]  dram_addr_n;
  logic        ack_n, busy_n, ras_n_n, cas_n_n, wr_n_n, rd_n_n;

`ifdef CHARRAM_REFRESH_EN
  localparam logic [9:0] TIMER_LAST = 10'(REFRESH_INTERVAL - 1);
  logic [9:0] timer_q, timer_n;
  logic       pending_q, pending_n;
  logic [7:0] ref_row_q, ref_row_n;
  logic       ref_cnt_q, ref_cnt_n;
`endif

  // Outputs are computed from the next state so every strobe comes straight off a flop.
  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    we_n      = we_q;
    din_n     = din_q;
    pre_cnt_n = pre_cnt_q;
    ack_n     = 1'b0;
    dout_n    = o_DOUT;
`ifdef CHARRAM_REFRESH_EN
    pending_n = pending_q;
    ref_row_n = ref_row_q;
    ref_cnt_n = ref_cnt_q;
    timer_n   = (timer_q == TIMER_LAST) ? '0 : timer_q + 10'd1;
`endif

    case (state)
      IDLE: begin
`ifdef CHARRAM_REFRESH_EN
        if (pending_q) begin
          state_n   = REF;
          pending_n = 1'b0;
          ref_cnt_n = 1'b0;
        end else
`endif
        if (i_REQ) begin
          addr_n  = i_ADDR;
          we_n    = i_WE;
          din_n   = i_DIN;
          state_n = ROW;
        end
      end
      ROW: state_n = COL;
      COL: state_n = ACC;
      ACC: begin
        if (we_q) begin
          state_n   = PRE;
          pre_cnt_n = PRE_LAST;
          ack_n     = 1'b1;
        end else begin
          state_n = RDLAT;
        end
      end
      RDLAT: begin
        state_n   = PRE;
        pre_cnt_n = PRE_LAST;
        ack_n     = 1'b1;
        dout_n    = i_DRAM_DIN;
      end
      PRE: begin
        if (pre_cnt_q == '0) state_n = IDLE;
        else                 pre_cnt_n = pre_cnt_q - 3'd1;
      end
`ifdef CHARRAM_REFRESH_EN
      REF: begin
        if (ref_cnt_q) begin
          state_n   = PRE;
          pre_cnt_n = PRE_LAST;
          ref_row_n = ref_row_q + 8'd1;
        end else begin
          ref_cnt_n = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

`ifdef CHARRAM_REFRESH_EN
    // A wrap coinciding with REF entry re-arms pending rather than being lost.
    if (timer_q == TIMER_LAST) pending_n = 1'b1;
`endif

    ras_n_n     = 1'b1;
    cas_n_n     = 1'b1;
    wr_n_n      = 1'b1;
    rd_n_n      = 1'b1;
    dram_addr_n = o_DRAM_ADDR;
    dram_dout_n = o_DRAM_DOUT;
    busy_n      = (state_n != IDLE);

    case (state_n)
      ROW: begin
        ras_n_n     = 1'b0;
        dram_addr_n = addr_n[7:0];
      end
      COL: begin
        ras_n_n     = 1'b0;
        cas_n_n     = 1'b0;
        dram_addr_n = {1'b0, addr_n[13:8], 1'b0};
      end
      ACC: begin
        ras_n_n = 1'b0;
        cas_n_n = 1'b0;
        if (we_n) begin
          wr_n_n      = 1'b0;
          dram_dout_n = din_n;
        end else begin
          rd_n_n = 1'b0;
        end
      end
      RDLAT: begin
        ras_n_n = 1'b0;
        cas_n_n = 1'b0;
      end
`ifdef CHARRAM_REFRESH_EN
      REF: begin
        ras_n_n     = 1'b0;
        dram_addr_n = ref_row_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      din_q       <= '0;
      pre_cnt_q   <= '0;
      o_DOUT      <= '0;
      o_ACK       <= 1'b0;
      o_BUSY      <= 1'b0;
      o_DRAM_ADDR <= '0;
      o_DRAM_DOUT <= '0;
      o_RAS_n     <= 1'b1;
      o_CAS_n     <= 1'b1;
      o_WR_n      <= 1'b1;
      o_RD_n      <= 1'b1;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      we_q        <= we_n;
      din_q       <= din_n;
      pre_cnt_q   <= pre_cnt_n;
      o_DOUT      <= dout_n;
      o_ACK       <= ack_n;
      o_BUSY      <= busy_n;
      o_DRAM_ADDR <= dram_addr_n;
      o_DRAM_DOUT <= dram_dout_n;
      o_RAS_n     <= ras_n_n;
      o_CAS_n     <= cas_n_n;
      o_WR_n      <= wr_n_n;
      o_RD_n      <= rd_n_n;
    end
  end

`ifdef CHARRAM_REFRESH_EN
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
      ref_row_q <= '0;
      ref_cnt_q <= 1'b0;
    end else begin
      timer_q   <= timer_n;
      pending_q <= pending_n;
      ref_row_q <= ref_row_n;
      ref_cnt_q <= ref_cnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Self-checking bench for charram_dram_ctrl with a behavioural 4416 DRAM model
// and a read-data scoreboard; define CHARRAM_REFRESH_EN to add the refresh scenario.
module tb_charram_dram_ctrl;
  localparam int P = 2;
`ifdef CHARRAM_REFRESH_EN
  localparam int RI = 16;
`else
  localparam int RI = 128;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [13:0] addr = '0;
  logic [3:0]  din = '0;
  logic [3:0]  dout;
  logic        ack, busy;
  logic [7:0]  dram_addr;
  logic        ras_n, cas_n, wr_n, rd_n;
  logic [3:0]  dram_dout;
  logic [3:0]  dram_din = '0;

  int total = 0;
  int bad = 0;
  int viol = 0;

  logic [3:0] shadow [0:16383];
  logic [3:0] exp_q [$];

  charram_dram_ctrl #(.REFRESH_INTERVAL(RI), .PRECHARGE_CYCLES(P)) dut (
    .i_MCLK(clk), .i_RST_n(rst_n), .i_REQ(req), .i_WE(we), .i_ADDR(addr), .i_DIN(din),
    .o_DOUT(dout), .o_ACK(ack), .o_BUSY(busy), .o_DRAM_ADDR(dram_addr),
    .o_RAS_n(ras_n), .o_CAS_n(cas_n), .o_WR_n(wr_n), .o_RD_n(rd_n),
    .o_DRAM_DOUT(dram_dout), .i_DRAM_DIN(dram_din)
  );

  always #5 clk = ~clk;

  // 4416 model: row latched on RAS-only cycles, column on the first RAS+CAS cycle.
  logic [3:0] mem [0:16383];
  logic [7:0] m_row = '0;
  logic [5:0] m_col = '0;
  always @(posedge clk) begin
    if (!ras_n && cas_n) m_row <= dram_addr;
    if (!ras_n && !cas_n && wr_n && rd_n) m_col <= dram_addr[6:1];
    if (!wr_n) mem[{m_col, m_row}] <= dram_dout;
    if (!rd_n) dram_din <= mem[{m_col, m_row}];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!wr_n && !rd_n) viol++;
      if ((!wr_n || !rd_n) && (ras_n || cas_n)) viol++;
    end
  end

  task automatic do_access(input logic w, input logic [13:0] a, input logic [3:0] d,
                           input bit hold, input bit scramble,
                           output int ack_c, output int col_c, output logic [7:0] row_a,
                           output logic [7:0] col_a, output int wr_c, output int rd_c);
    int g;
    logic [7:0] prev_addr;
    logic [3:0] e;
    g = 0;
    while (busy && g < 100) begin @(negedge clk); g++; end
    req = 1'b1; we = w; addr = a; din = d;
    if (w) shadow[a] = d;
    else exp_q.push_back(shadow[a]);
    ack_c = -1; col_c = -1; wr_c = 0; rd_c = 0; row_a = '0; col_a = '0; prev_addr = '0;
    for (int k = 1; k <= 40 && ack_c < 0; k++) begin
      @(negedge clk);
      if (!ras_n && !cas_n && col_c < 0) begin
        col_c = k; col_a = dram_addr; row_a = prev_addr;
        if (scramble) begin addr = a ^ 14'h3FFF; din = ~d; we = ~w; end
      end
      prev_addr = dram_addr;
      if (!wr_n) wr_c++;
      if (!rd_n) rd_c++;
      if (ack) begin
        ack_c = k;
        if (!hold) req = 1'b0;
        if (!w) begin
          e = exp_q.pop_front();
          total++;
          if (dout !== e) begin bad++; $display("FAIL read_data addr=%h got=%h want=%h", a, dout, e); end
        end
      end
    end
    if (ack_c < 0) begin
      req = 1'b0;
      total++; bad++;
      $display("FAIL ack_timeout addr=%h got=none want=ack", a);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({ras_n, cas_n, wr_n, rd_n} !== 4'hF) begin bad++; $display("FAIL reset_strobes got=%b want=1111", {ras_n, cas_n, wr_n, rd_n}); end
    total++; if ({ack, busy} !== 2'b00) begin bad++; $display("FAIL reset_ack_busy got=%b want=00", {ack, busy}); end
    total++; if (dout !== 4'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", dout); end
    total++; if ({dram_addr, dram_dout} !== 12'h000) begin bad++; $display("FAIL reset_dram_bus got=%h want=000", {dram_addr, dram_dout}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write;
    int ac, cc, wc, rc;
    logic [7:0] ra, ca;
    do_access(1'b1, 14'h2A5C, 4'hB, 1'b0, 1'b0, ac, cc, ra, ca, wc, rc);
    total++; if (ra !== 8'h5C) begin bad++; $display("FAIL write_row_addr got=%h want=5c", ra); end
    total++; if (ca !== 8'h54) begin bad++; $display("FAIL write_col_addr got=%h want=54", ca); end
    total++; if (wc != 1 || rc != 0) begin bad++; $display("FAIL write_strobes got=wr%0d/rd%0d want=wr1/rd0", wc, rc); end
    total++; if (ac != cc + 2) begin bad++; $display("FAIL write_ack_rel got=%0d want=%0d", ac, cc + 2); end
`ifndef CHARRAM_REFRESH_EN
    total++; if (ac != 4) begin bad++; $display("FAIL write_ack_cycle got=%0d want=4", ac); end
`endif
  endtask

  task automatic test_read;
    int ac, cc, wc, rc;
    logic [7:0] ra, ca;
    do_access(1'b0, 14'h2A5C, 4'h0, 1'b0, 1'b0, ac, cc, ra, ca, wc, rc);
    total++; if (rc != 1 || wc != 0) begin bad++; $display("FAIL read_strobes got=wr%0d/rd%0d want=wr0/rd1", wc, rc); end
    total++; if (ac != cc + 3) begin bad++; $display("FAIL read_ack_rel got=%0d want=%0d", ac, cc + 3); end
`ifndef CHARRAM_REFRESH_EN
    total++; if (ac != 5) begin bad++; $display("FAIL read_ack_cycle got=%0d want=5", ac); end
`endif
    // Read data must survive an intervening write.
    do_access(1'b1, 14'h0001, 4'h3, 1'b0, 1'b0, ac, cc, ra, ca, wc, rc);
    total++; if (dout !== 4'hB) begin bad++; $display("FAIL dout_hold got=%h want=b", dout); end
  endtask

  task automatic test_random;
    int ac, cc, wc, rc;
    logic [7:0] ra, ca;
    logic [13:0] a;
    logic [3:0] d;
    for (int i = 0; i < 6; i++) begin
      a = 14'($urandom_range(0, 16383));
      d = 4'($urandom_range(0, 15));
      do_access(1'b1, a, d, 1'b0, i[0], ac, cc, ra, ca, wc, rc);
      total++; if (ra !== a[7:0] || ca !== {1'b0, a[13:8], 1'b0}) begin bad++; $display("FAIL rand_addr got=%h/%h want=%h/%h", ra, ca, a[7:0], {1'b0, a[13:8], 1'b0}); end
      do_access(1'b0, a, 4'h0, 1'b0, ~i[0], ac, cc, ra, ca, wc, rc);
      total++; if (ac != cc + 3) begin bad++; $display("FAIL rand_read_ack got=%0d want=%0d", ac, cc + 3); end
    end
  endtask

  task automatic test_back_to_back;
    int ac, cc, wc, rc, ras_hi, row_k, ack2_k;
    logic [7:0] ra, ca;
    logic idle_seen;
    do_access(1'b1, 14'h0F0F, 4'h6, 1'b1, 1'b0, ac, cc, ra, ca, wc, rc);
    ras_hi = (ras_n && busy) ? 1 : 0;
    row_k = -1; ack2_k = -1; idle_seen = 1'b0;
    for (int k = 1; k <= 30 && ack2_k < 0; k++) begin
      @(negedge clk);
      if (row_k < 0 && ras_n && busy) ras_hi++;
      if (row_k < 0 && !busy) idle_seen = 1'b1;
      if (row_k < 0 && !ras_n && cas_n) begin row_k = k; req = 1'b0; end
      if (ack) ack2_k = k;
    end
    req = 1'b0;
    total++; if (row_k != P + 1) begin bad++; $display("FAIL b2b_row_gap got=%0d want=%0d", row_k, P + 1); end
    total++; if (ras_hi != P) begin bad++; $display("FAIL b2b_precharge got=%0d want=%0d", ras_hi, P); end
    total++; if (!idle_seen) begin bad++; $display("FAIL b2b_idle got=0 want=1"); end
    total++; if (ack2_k != row_k + 3) begin bad++; $display("FAIL b2b_second_ack got=%0d want=%0d", ack2_k, row_k + 3); end
    do_access(1'b0, 14'h0F0F, 4'h0, 1'b0, 1'b0, ac, cc, ra, ca, wc, rc);
  endtask

  task automatic test_reset_mid;
    int ac, cc, wc, rc, acks;
    logic [7:0] ra, ca;
    bit found;
    found = 1'b0; acks = 0;
    while (busy) @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 14'h1234; din = 4'h5;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (!wr_n) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rstmid_acc got=none want=wr_low"); end
    #2 rst_n = 1'b0;
    #1;
    req = 1'b0;
    total++; if ({ras_n, cas_n, wr_n, rd_n} !== 4'hF || ack !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_strobes got=%b want=111100", {ras_n, cas_n, wr_n, rd_n, ack, busy});
    end
    repeat (3) begin @(negedge clk); if (ack) acks++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (ack) acks++; end
    total++; if (acks != 0) begin bad++; $display("FAIL rstmid_no_ack got=%0d want=0", acks); end
    do_access(1'b1, 14'h2222, 4'h9, 1'b0, 1'b0, ac, cc, ra, ca, wc, rc);
    total++; if (ac != cc + 2) begin bad++; $display("FAIL rstmid_recover got=%0d want=%0d", ac, cc + 2); end
    do_access(1'b0, 14'h2222, 4'h0, 1'b0, 1'b0, ac, cc, ra, ca, wc, rc);
  endtask

`ifdef CHARRAM_REFRESH_EN
  task automatic test_refresh;
    int refs, row_err, ack_k, rowacc_k, pre_acks;
    logic prev_ras;
    logic [7:0] exp_row, last_row, acc_row;
    rst_n = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (RI) @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 14'h0357; din = 4'hC; shadow[14'h0357] = 4'hC;
    @(negedge clk);
    total++; if (ras_n !== 1'b0 || cas_n !== 1'b1 || dram_addr !== 8'h00) begin bad++; $display("FAIL ref_first got=%b%b/%h want=01/00", ras_n, cas_n, dram_addr); end
    @(negedge clk);
    total++; if (ras_n !== 1'b0 || cas_n !== 1'b1 || dram_addr !== 8'h00) begin bad++; $display("FAIL ref_second got=%b%b/%h want=01/00", ras_n, cas_n, dram_addr); end
    ack_k = -1; rowacc_k = -1; pre_acks = 0; acc_row = '0;
    for (int k = 3; k <= 30 && ack_k < 0; k++) begin
      @(negedge clk);
      if (rowacc_k < 0 && ack) pre_acks++;
      if (rowacc_k < 0 && !ras_n && cas_n) begin rowacc_k = k; acc_row = dram_addr; end
      if (rowacc_k >= 0 && ack) ack_k = k;
    end
    req = 1'b0;
    total++; if (pre_acks != 0) begin bad++; $display("FAIL ref_no_ack got=%0d want=0", pre_acks); end
    total++; if (acc_row !== 8'h57 || ack_k != rowacc_k + 3) begin bad++; $display("FAIL ref_then_access got=%h@%0d want=57@%0d", acc_row, ack_k, rowacc_k + 3); end
    refs = 0; row_err = 0; exp_row = 8'h01; last_row = 8'hFF; prev_ras = 1'b1;
    for (int c = 0; c < 256 * RI + 200 && refs < 256; c++) begin
      @(negedge clk);
      if (!ras_n && cas_n && prev_ras) begin
        if (dram_addr !== exp_row) row_err++;
        last_row = dram_addr;
        exp_row++;
        refs++;
      end
      prev_ras = ras_n;
    end
    total++; if (refs != 256 || row_err != 0) begin bad++; $display("FAIL ref_sequence got=%0d/%0d want=256/0", refs, row_err); end
    total++; if (last_row !== 8'h00) begin bad++; $display("FAIL ref_wrap got=%h want=00", last_row); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef CHARRAM_REFRESH_EN
    test_refresh();
`endif
    test_write();
    test_read();
    test_random();
`ifndef CHARRAM_REFRESH_EN
    test_back_to_back();
    test_reset_mid();
`endif
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    total++; if (viol != 0) begin bad++; $display("FAIL strobe_rules got=%0d want=0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
